// File: rtl/dco_pkg.sv
// Shared command/status encodings for the digitally controlled oscillator
// and the frequency-lock controller that drives it.
package dco_pkg;

    typedef logic [1:0] ctl_t;
    typedef logic [1:0] status_t;

    localparam ctl_t CTL_HOLD   = 2'b00;
    localparam ctl_t CTL_FASTER = 2'b10;
    localparam ctl_t CTL_SLOWER = 2'b11;

    localparam status_t ST_OK  = 2'b00;
    localparam status_t ST_MIN = 2'b01;
    localparam status_t ST_MAX = 2'b10;

endpackage

// File: rtl/dco_divider_if.sv
// ctl/status link between the lock controller (master) and the DCO (slave),
// plus the generated clock and the current half-period for observation.
interface dco_divider_if #(
    parameter int WIDTH = 16
) ();
    import dco_pkg::*;

    ctl_t             ctl;
    logic             out;
    status_t          status;
    logic [WIDTH-1:0] period;

    modport master (
        output ctl,
        input  out,
        input  status,
        input  period
    );

    modport slave (
        input  ctl,
        output out,
        output status,
        output period
    );

endinterface

// File: rtl/dco_divider_sync2.sv
// Two-flop synchronizer for multi-bit level signals coming from another
// clock domain; every bit passes through the same pair of stages.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/dco_divider.sv
// Digitally controlled oscillator: divides clk by a programmable half-period
// that is nudged one STEP per half-period by the synchronized ctl command.
module dco_divider
    import dco_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int P_INIT = 100,
    parameter int P_MIN  = 2,
    parameter int P_MAX  = 65535,
    parameter int STEP   = 1
) (
    input  logic          clk,
    input  logic          resn,
    dco_divider_if.slave  bus
);

    localparam logic [WIDTH-1:0] L_P_INIT = WIDTH'(P_INIT);
    localparam logic [WIDTH-1:0] L_P_MIN  = WIDTH'(P_MIN);
    localparam logic [WIDTH-1:0] L_P_MAX  = WIDTH'(P_MAX);
    localparam logic [WIDTH-1:0] L_ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   L_MIN_X  = (WIDTH+1)'(P_MIN);
    localparam logic [WIDTH:0]   L_MAX_X  = (WIDTH+1)'(P_MAX);
    localparam logic [WIDTH:0]   L_STEP_X = (WIDTH+1)'(STEP);

    function automatic status_t status_of(input logic [WIDTH-1:0] p);
        if (p == L_P_MIN)      return ST_MIN;
        else if (p == L_P_MAX) return ST_MAX;
        else                   return ST_OK;
    endfunction

    ctl_t             w_ctl_s;
    logic             w_toggle;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic             w_borrow;
    logic [WIDTH-1:0] w_p_next;

    logic [WIDTH-1:0] r_hc;
    logic [WIDTH-1:0] r_p;
    logic             r_out;
    status_t          r_status;

    sync2 #(.WIDTH(2)) u_sync (
        .clk  (clk),
        .resn (resn),
        .i_d  (bus.ctl),
        .o_q  (w_ctl_s)
    );

    assign w_toggle = (r_hc == (r_p - L_ONE));

    // One extra bit keeps the sum and difference free of wrap-around; the
    // borrow flag catches a decrement that would go below zero.
    always_comb begin
        w_inc    = {1'b0, r_p} + L_STEP_X;
        w_dec    = {1'b0, r_p} - L_STEP_X;
        w_borrow = ({1'b0, r_p} < L_STEP_X);
        w_p_next = r_p;
        case (w_ctl_s)
            CTL_SLOWER: begin
                if (w_inc > L_MAX_X) w_p_next = L_P_MAX;
                else                 w_p_next = w_inc[WIDTH-1:0];
            end
            CTL_FASTER: begin
                if (w_borrow || (w_dec < L_MIN_X)) w_p_next = L_P_MIN;
                else                               w_p_next = w_dec[WIDTH-1:0];
            end
            default: w_p_next = r_p;
        endcase
    end

    // P only moves on a toggle edge, so a half-period in progress is never cut short.
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_hc     <= '0;
            r_p      <= L_P_INIT;
            r_out    <= 1'b0;
            r_status <= status_of(L_P_INIT);
        end else if (w_toggle) begin
            r_hc     <= '0;
            r_out    <= ~r_out;
            r_p      <= w_p_next;
            r_status <= status_of(w_p_next);
        end else begin
            r_hc     <= r_hc + L_ONE;
        end
    end

    assign bus.out    = r_out;
    assign bus.status = r_status;
    assign bus.period = r_p;

endmodule

// File: tb/tb_dco_divider.sv
// Testbench for dco_divider: directed table, hand-written corner sequences
// and a randomized run against an event-time reference model.
module tb_dco_divider;
    import dco_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn0, rn1, rn2, rn3, rn4;

    dco_divider_if #(.WIDTH(16)) if0 ();
    dco_divider_if #(.WIDTH(4))  if1 ();
    dco_divider_if #(.WIDTH(16)) if2 ();
    dco_divider_if #(.WIDTH(16)) if3 ();
    dco_divider_if #(.WIDTH(6))  if4 ();

    dco_divider #(.WIDTH(16), .P_INIT(4), .P_MIN(2), .P_MAX(65535), .STEP(1))
        u0 (.clk(clk), .resn(rn0), .bus(if0));
    dco_divider #(.WIDTH(4), .P_INIT(14), .P_MIN(2), .P_MAX(15), .STEP(3))
        u1 (.clk(clk), .resn(rn1), .bus(if1));
    dco_divider #(.WIDTH(16), .P_INIT(3), .P_MIN(2), .P_MAX(65535), .STEP(5))
        u2 (.clk(clk), .resn(rn2), .bus(if2));
    dco_divider #(.WIDTH(16), .P_INIT(8), .P_MIN(2), .P_MAX(65535), .STEP(1))
        u3 (.clk(clk), .resn(rn3), .bus(if3));
    dco_divider #(.WIDTH(6), .P_INIT(5), .P_MIN(1), .P_MAX(10), .STEP(2))
        u4 (.clk(clk), .resn(rn4), .bus(if4));

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        ctl_t       ctl;
        int         adv;
        logic       out;
        int         period;
        status_t    status;
    } vec_t;

    vec_t tbl[12];

    logic [1:0] hist[0:4095];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1);
    end

    initial begin
        int   m_p, m_next, n, cs;
        logic m_out;
        ctl_t c;
        logic [1:0] m_st;
        bit   found;

        rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0; rn3 = 1'b0; rn4 = 1'b0;
        if0.ctl = CTL_HOLD;
        if1.ctl = CTL_SLOWER;
        if2.ctl = CTL_FASTER;
        if3.ctl = CTL_HOLD;
        if4.ctl = CTL_HOLD;

        // free-run then hold "faster": 4 -> 3 -> 2, then clamped at 2
        tbl[0]  = '{CTL_HOLD,   3, 1'b0, 4, ST_OK};
        tbl[1]  = '{CTL_HOLD,   1, 1'b1, 4, ST_OK};
        tbl[2]  = '{CTL_HOLD,   3, 1'b1, 4, ST_OK};
        tbl[3]  = '{CTL_HOLD,   1, 1'b0, 4, ST_OK};
        tbl[4]  = '{CTL_FASTER, 3, 1'b0, 4, ST_OK};
        tbl[5]  = '{CTL_FASTER, 1, 1'b1, 3, ST_OK};
        tbl[6]  = '{CTL_FASTER, 2, 1'b1, 3, ST_OK};
        tbl[7]  = '{CTL_FASTER, 1, 1'b0, 2, ST_MIN};
        tbl[8]  = '{CTL_FASTER, 1, 1'b0, 2, ST_MIN};
        tbl[9]  = '{CTL_FASTER, 1, 1'b1, 2, ST_MIN};
        tbl[10] = '{CTL_FASTER, 2, 1'b0, 2, ST_MIN};
        tbl[11] = '{CTL_HOLD,   2, 1'b1, 2, ST_MIN};

        adv(3);
        check("rst_out",    {31'd0, if0.out}, 32'd0);
        check("rst_period", {16'd0, if0.period}, 32'd4);
        check("rst_status", {30'd0, if0.status}, 32'd0);
        check("rst_u1_status", {30'd0, if1.status}, 32'd0);

        rn0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if0.ctl = tbl[i].ctl;
            adv(tbl[i].adv);
            check($sformatf("tbl%0d_out", i),    {31'd0, if0.out},    {31'd0, tbl[i].out});
            check($sformatf("tbl%0d_period", i), {16'd0, if0.period}, tbl[i].period);
            check($sformatf("tbl%0d_status", i), {30'd0, if0.status}, {30'd0, tbl[i].status});
        end

        // slower with saturation: 14 + 3 clamps to 15
        rn1 = 1'b1;
        adv(13);
        check("sat_pre_period", {28'd0, if1.period}, 32'd14);
        check("sat_pre_out",    {31'd0, if1.out},    32'd0);
        adv(1);
        check("sat_period", {28'd0, if1.period}, 32'd15);
        check("sat_status", {30'd0, if1.status}, {30'd0, ST_MAX});
        check("sat_out",    {31'd0, if1.out},    32'd1);
        adv(14);
        check("sat2_pre_out", {31'd0, if1.out}, 32'd1);
        adv(1);
        check("sat2_out",    {31'd0, if1.out},    32'd0);
        check("sat2_period", {28'd0, if1.period}, 32'd15);
        check("sat2_status", {30'd0, if1.status}, {30'd0, ST_MAX});

        // 3 - 5 must clamp to P_MIN, not wrap
        rn2 = 1'b1;
        adv(2);
        check("unf_pre_period", {16'd0, if2.period}, 32'd3);
        adv(1);
        check("unf_period", {16'd0, if2.period}, 32'd2);
        check("unf_status", {30'd0, if2.status}, {30'd0, ST_MIN});
        check("unf_out",    {31'd0, if2.out},    32'd1);
        adv(2);
        check("unf2_out",    {31'd0, if2.out},    32'd0);
        check("unf2_period", {16'd0, if2.period}, 32'd2);

        // ctl pulse between toggles is ignored; one spanning a toggle is seen
        rn3 = 1'b1;
        adv(9);
        check("pulse_e9_out", {31'd0, if3.out}, 32'd1);
        if3.ctl = CTL_FASTER;
        adv(3);
        if3.ctl = CTL_HOLD;
        adv(4);
        check("pulse_e16_out",    {31'd0, if3.out},    32'd0);
        check("pulse_e16_period", {16'd0, if3.period}, 32'd8);
        adv(4);
        if3.ctl = CTL_FASTER;
        adv(3);
        check("pulse_e23_period", {16'd0, if3.period}, 32'd8);
        if3.ctl = CTL_HOLD;
        adv(1);
        check("pulse_e24_period", {16'd0, if3.period}, 32'd7);
        check("pulse_e24_out",    {31'd0, if3.out},    32'd1);
        adv(6);
        check("pulse_e30_out", {31'd0, if3.out}, 32'd1);
        adv(1);
        check("pulse_e31_out",    {31'd0, if3.out},    32'd0);
        check("pulse_e31_period", {16'd0, if3.period}, 32'd7);

        // ramp u0 to P=20, stop at out=1, hc=5, then reset mid half-period
        if0.ctl = CTL_SLOWER;
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            adv(1);
            if (if0.period == 16'd20) found = 1'b1;
        end
        if0.ctl = CTL_HOLD;
        check("ramp_reached", {31'd0, found}, 32'd1);
        if (found && if0.out == 1'b0) begin
            found = 1'b0;
            for (int k = 0; k < 50 && !found; k++) begin
                adv(1);
                if (if0.out == 1'b1) found = 1'b1;
            end
            check("ramp_out_high", {31'd0, found}, 32'd1);
        end
        adv(5);
        #2 rn0 = 1'b0;
        #1;
        check("mid_rst_out",    {31'd0, if0.out},    32'd0);
        check("mid_rst_period", {16'd0, if0.period}, 32'd4);
        check("mid_rst_status", {30'd0, if0.status}, 32'd0);
        @(negedge clk);
        rn0 = 1'b1;
        adv(3);
        check("post_rst_e3_out", {31'd0, if0.out}, 32'd0);
        adv(1);
        check("post_rst_e4_out",    {31'd0, if0.out},    32'd1);
        check("post_rst_e4_period", {16'd0, if0.period}, 32'd4);

        // randomized run: model tracks toggle times and P with plain arithmetic
        m_p = 5; m_out = 1'b0; m_next = 5; n = 0; c = CTL_HOLD;
        rn4 = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) c = ctl_t'($urandom_range(0, 3));
            if4.ctl = c;
            @(posedge clk);
            n++;
            hist[n] = c;
            if (n == m_next) begin
                cs = (n >= 3) ? int'(hist[n-2]) : 0;
                m_out = ~m_out;
                if (cs == 3)      m_p = (m_p + 2 > 10) ? 10 : m_p + 2;
                else if (cs == 2) m_p = (m_p - 2 < 1)  ? 1  : m_p - 2;
                m_next = n + m_p;
            end
            m_st = (m_p == 1) ? ST_MIN : (m_p == 10) ? ST_MAX : ST_OK;
            @(negedge clk);
            check($sformatf("rand_e%0d {out,status,period}", n),
                  {23'd0, if4.out, if4.status, if4.period},
                  {23'd0, m_out, m_st, 6'(m_p)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
